// File: rtl/fuzz_seq_pkg.sv
// Shared types, parameter defaults and small arithmetic helpers for the
// fuzzing round sequencer and its stall monitor.
package fuzz_seq_pkg;

  // Sequencer phases over the life of a fuzzing round.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RSTHOLD = 3'd1,
    ST_RUN     = 3'd2,
    ST_HALT    = 3'd3,
    ST_RELOAD  = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

  // Outcome of the most recent round.
  typedef enum logic [1:0] {
    STATUS_NONE    = 2'd0,
    STATUS_PASS    = 2'd1,
    STATUS_TIMEOUT = 2'd2
  } round_status_t;

  localparam int unsigned     DEF_MAX_WAIT_CYCLE = 1000;
  localparam int unsigned     DEF_WATCHDOG_LIMIT = 50000;
  localparam longint unsigned DEF_MAX_CYCLES     = 64'd2000000000;
  localparam int unsigned     DEF_RESET_HOLD     = 4;

  // The stall threshold scales with the coverage "difficulty" field. With an
  // 11-bit scale and any sane base the product stays well inside 32 bits.
  function automatic logic [31:0] stall_threshold(input logic [31:0] base,
                                                  input logic [10:0] scale);
    return base * ({21'd0, scale} + 32'd1);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

  function automatic logic [63:0] sat_inc64(input logic [63:0] value);
    return (value == '1) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/fuzz_stall_monitor.sv
// Watches coverage progress and the tohost pass bit while the DUT runs, and
// raises the stall interrupt when coverage stops moving for too long or the
// DUT has gone too long without reporting a pass.
module fuzz_stall_monitor
  import fuzz_seq_pkg::*;
#(
  parameter int unsigned MAX_WAIT_CYCLE = DEF_MAX_WAIT_CYCLE,
  parameter int unsigned WATCHDOG_LIMIT = DEF_WATCHDOG_LIMIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        run,
  input  logic        pass,
  input  logic [29:0] cov,
  output logic        stall_irq
);

  logic [31:0] stall_count;
  logic [31:0] watchdog_count;
  logic [29:0] pre_cov;
  logic [31:0] threshold;
  logic        cov_changed;

  assign threshold   = stall_threshold(32'(MAX_WAIT_CYCLE), cov[29:19]);
  assign cov_changed = (cov != pre_cov);

  // Count cycles since coverage last moved and since the last pass; a pass
  // restarts both, a coverage change restarts only the stall count.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      stall_count    <= '0;
      watchdog_count <= '0;
      pre_cov        <= '0;
    end else if (run) begin
      if (cov_changed) begin
        pre_cov <= cov;
      end
      if (pass || cov_changed) begin
        stall_count <= '0;
      end else begin
        stall_count <= sat_inc32(stall_count);
      end
      if (pass) begin
        watchdog_count <= '0;
      end else begin
        watchdog_count <= sat_inc32(watchdog_count);
      end
    end
  end

  assign stall_irq = run &&
                     ((stall_count >= threshold) ||
                      (watchdog_count >= 32'(WATCHDOG_LIMIT)));

endmodule

// File: rtl/fuzz_round_sequencer.sv
// Round sequencer for the co-simulation fuzzer: holds the DUT in reset, lets
// it run until it passes or times out, then hands control to the loader and
// either starts another round or stops.
module fuzz_round_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int unsigned     MAX_WAIT_CYCLE = DEF_MAX_WAIT_CYCLE,
  parameter int unsigned     WATCHDOG_LIMIT = DEF_WATCHDOG_LIMIT,
  parameter longint unsigned MAX_CYCLES     = DEF_MAX_CYCLES,
  parameter int unsigned     RESET_HOLD     = DEF_RESET_HOLD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] tohost,
  input  logic [29:0] cov,
  input  logic        reload_ack,
  input  logic        reload_continue,
  output logic        dut_reset,
  output logic        clk_en,
  output logic        stall_irq,
  output logic        reload_req,
  output logic        round_done,
  output logic [1:0]  round_status,
  output logic [63:0] cycle_count
);

  seq_state_t    state;
  round_status_t status_q;
  logic [31:0]   hold_count;
  logic [63:0]   count_next;
  logic          pass;
  logic          timeout;
  logic          run;
  logic          clear;
  logic          unused_tohost;

  // Only bit 0 of tohost carries meaning for the sequencer.
  assign unused_tohost = ^tohost[63:1];
  assign pass          = tohost[0];

  // The timeout compares the count including the current RUN cycle, so a
  // round with MAX_CYCLES=N halts after exactly N RUN cycles.
  assign count_next = sat_inc64(cycle_count);
  assign timeout    = (count_next >= MAX_CYCLES);

  assign run          = (state == ST_RUN);
  assign clear        = (state == ST_RSTHOLD);
  assign round_status = status_q;

  fuzz_stall_monitor #(
    .MAX_WAIT_CYCLE(MAX_WAIT_CYCLE),
    .WATCHDOG_LIMIT(WATCHDOG_LIMIT)
  ) u_stall_monitor (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .run      (run),
    .pass     (pass),
    .cov      (cov),
    .stall_irq(stall_irq)
  );

  // Round state machine; every output is set on the transition into the
  // state that owns it so the outputs stay registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      status_q    <= STATUS_NONE;
      hold_count  <= '0;
      cycle_count <= '0;
      dut_reset   <= 1'b1;
      clk_en      <= 1'b1;
      reload_req  <= 1'b0;
      round_done  <= 1'b0;
    end else begin
      round_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RSTHOLD;
            status_q    <= STATUS_NONE;
            hold_count  <= '0;
            cycle_count <= '0;
            dut_reset   <= 1'b1;
            clk_en      <= 1'b1;
          end
        end
        ST_RSTHOLD: begin
          if (hold_count >= 32'(RESET_HOLD - 1)) begin
            state     <= ST_RUN;
            dut_reset <= 1'b0;
            clk_en    <= 1'b1;
          end else begin
            hold_count <= hold_count + 32'd1;
          end
        end
        ST_RUN: begin
          cycle_count <= count_next;
          if (pass) begin
            state      <= ST_HALT;
            status_q   <= STATUS_PASS;
            clk_en     <= 1'b0;
            round_done <= 1'b1;
          end else if (timeout) begin
            state      <= ST_HALT;
            status_q   <= STATUS_TIMEOUT;
            clk_en     <= 1'b0;
            round_done <= 1'b1;
          end
        end
        ST_HALT: begin
          state      <= ST_RELOAD;
          reload_req <= 1'b1;
        end
        ST_RELOAD: begin
          if (reload_ack) begin
            reload_req <= 1'b0;
            if (reload_continue) begin
              state       <= ST_RSTHOLD;
              status_q    <= STATUS_NONE;
              hold_count  <= '0;
              cycle_count <= '0;
              dut_reset   <= 1'b1;
              clk_en      <= 1'b1;
            end else begin
              state     <= ST_DONE;
              dut_reset <= 1'b1;
              clk_en    <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state      <= ST_IDLE;
          status_q   <= STATUS_NONE;
          dut_reset  <= 1'b1;
          clk_en     <= 1'b1;
          reload_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_round_sequencer.sv
// Bench for the fuzz round sequencer: two instances (default limits, and a
// short round limit) checked every cycle against a behavioural model, plus
// literal expectations for the key scenarios.
module tb_fuzz_round_sequencer;

  localparam int PH_IDLE   = 0;
  localparam int PH_HOLD   = 1;
  localparam int PH_RUN    = 2;
  localparam int PH_HALT   = 3;
  localparam int PH_RELOAD = 4;
  localparam int PH_DONE   = 5;

  localparam logic [70:0] RESET_OUTS = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 64'd0};

  typedef struct {
    longint unsigned max_wait;
    longint unsigned wd_limit;
    longint unsigned max_cycles;
    int              hold;
  } cfg_t;

  typedef struct {
    int              phase;
    int              hold_left;
    longint unsigned cycles;
    int              status;
    longint unsigned since_change;
    longint unsigned since_pass;
    logic [29:0]     last_cov;
  } model_t;

  logic clock = 1'b1;
  logic reset;

  logic        a_start, a_ack, a_cont;
  logic [63:0] a_tohost;
  logic [29:0] a_cov;
  logic        a_dut_reset, a_clk_en, a_stall_irq, a_reload_req, a_round_done;
  logic [1:0]  a_round_status;
  logic [63:0] a_cycle_count;

  logic        b_start, b_ack, b_cont;
  logic [63:0] b_tohost;
  logic [29:0] b_cov;
  logic        b_dut_reset, b_clk_en, b_stall_irq, b_reload_req, b_round_done;
  logic [1:0]  b_round_status;
  logic [63:0] b_cycle_count;

  logic [70:0] a_outs, b_outs;

  int passed = 0;
  int total  = 0;

  cfg_t   ca = '{max_wait: 1000, wd_limit: 50000, max_cycles: 2000000000, hold: 4};
  cfg_t   cb = '{max_wait: 1000, wd_limit: 50000, max_cycles: 50, hold: 4};
  model_t ma, mb;
  bit     mvalid = 1'b0;

  always #5 clock = ~clock;

  assign a_outs = {a_dut_reset, a_clk_en, a_stall_irq, a_reload_req, a_round_done,
                   a_round_status, a_cycle_count};
  assign b_outs = {b_dut_reset, b_clk_en, b_stall_irq, b_reload_req, b_round_done,
                   b_round_status, b_cycle_count};

  fuzz_round_sequencer dut_a (
    .clock(clock), .reset(reset), .start(a_start), .tohost(a_tohost), .cov(a_cov),
    .reload_ack(a_ack), .reload_continue(a_cont), .dut_reset(a_dut_reset),
    .clk_en(a_clk_en), .stall_irq(a_stall_irq), .reload_req(a_reload_req),
    .round_done(a_round_done), .round_status(a_round_status), .cycle_count(a_cycle_count)
  );

  fuzz_round_sequencer #(
    .MAX_WAIT_CYCLE(1000), .WATCHDOG_LIMIT(50000), .MAX_CYCLES(64'd50), .RESET_HOLD(4)
  ) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .tohost(b_tohost), .cov(b_cov),
    .reload_ack(b_ack), .reload_continue(b_cont), .dut_reset(b_dut_reset),
    .clk_en(b_clk_en), .stall_irq(b_stall_irq), .reload_req(b_reload_req),
    .round_done(b_round_done), .round_status(b_round_status), .cycle_count(b_cycle_count)
  );

  // Single comparison helper shared by the per-cycle checker and literal checks.
  task automatic checkOutput(input string name, input logic [70:0] actual,
                             input logic [70:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    else
      passed++;
  endtask

  function automatic model_t freshModel();
    model_t m;
    m.phase = PH_IDLE; m.hold_left = 0; m.cycles = 0; m.status = 0;
    m.since_change = 0; m.since_pass = 0; m.last_cov = '0;
    return m;
  endfunction

  function automatic model_t enterHold(input cfg_t c);
    model_t m;
    m = freshModel();
    m.phase = PH_HOLD;
    m.hold_left = c.hold;
    return m;
  endfunction

  // One clock of round behaviour given the inputs sampled at that edge.
  function automatic model_t modelStep(input model_t m, input cfg_t c, input logic rst_n,
                                       input logic start, input logic pass,
                                       input logic [29:0] cov, input logic ack,
                                       input logic cont);
    model_t n;
    n = m;
    if (!rst_n) return freshModel();
    case (m.phase)
      PH_IDLE: if (start) n = enterHold(c);
      PH_HOLD: begin
        n.hold_left = m.hold_left - 1;
        if (n.hold_left == 0) n.phase = PH_RUN;
      end
      PH_RUN: begin
        n.cycles = m.cycles + 1;
        if (cov != m.last_cov) begin
          n.last_cov = cov;
          n.since_change = 0;
        end else begin
          n.since_change = m.since_change + 1;
        end
        n.since_pass = m.since_pass + 1;
        if (pass) begin
          n.since_change = 0; n.since_pass = 0; n.status = 1; n.phase = PH_HALT;
        end else if (n.cycles >= c.max_cycles) begin
          n.status = 2; n.phase = PH_HALT;
        end
      end
      PH_HALT: n.phase = PH_RELOAD;
      PH_RELOAD: if (ack) begin
        if (cont) n = enterHold(c);
        else n.phase = PH_DONE;
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [70:0] modelOutputs(input model_t m, input cfg_t c,
                                               input logic [29:0] cov);
    longint unsigned scale, thr;
    logic irq, drst, cen;
    scale = 0;
    scale[10:0] = cov[29:19];
    thr  = c.max_wait * (scale + 1);
    irq  = (m.phase == PH_RUN) && (m.since_change >= thr || m.since_pass >= c.wd_limit);
    drst = (m.phase == PH_IDLE) || (m.phase == PH_HOLD) || (m.phase == PH_DONE);
    cen  = (m.phase == PH_IDLE) || (m.phase == PH_HOLD) || (m.phase == PH_RUN);
    return {drst, cen, irq, m.phase == PH_RELOAD, m.phase == PH_HALT,
            2'(m.status), 64'(m.cycles)};
  endfunction

  // Compare both instances against the model every cycle, then advance the
  // model with the inputs the next rising edge will sample.
  always @(negedge clock) begin
    if (mvalid) begin
      checkOutput("A.cycle", a_outs, modelOutputs(ma, ca, a_cov));
      checkOutput("B.cycle", b_outs, modelOutputs(mb, cb, b_cov));
    end
    ma = modelStep(ma, ca, reset, a_start, a_tohost[0], a_cov, a_ack, a_cont);
    mb = modelStep(mb, cb, reset, b_start, b_tohost[0], b_cov, b_ack, b_cont);
    if (!reset) mvalid = 1'b1;
  end

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] randTohost(input logic pass);
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    t[0] = pass;
    return t;
  endfunction

  task automatic applyStimulus(input bit sel, input logic start, input logic [63:0] tohost,
                               input logic [29:0] cov, input logic ack, input logic cont);
    if (sel) begin
      b_start = start; b_tohost = tohost; b_cov = cov; b_ack = ack; b_cont = cont;
    end else begin
      a_start = start; a_tohost = tohost; a_cov = cov; a_ack = ack; a_cont = cont;
    end
  endtask

  function automatic logic inRun(input bit sel);
    return sel ? (b_clk_en && !b_dut_reset) : (a_clk_en && !a_dut_reset);
  endfunction

  task automatic waitRun(input bit sel, output int held);
    held = 0;
    for (int i = 0; i < 40; i++) begin
      if (inRun(sel)) return;
      held++;
      tick();
    end
    checkOutput(sel ? "B.run_wait" : "A.run_wait", 71'(inRun(sel)), 71'd1);
  endtask

  task automatic startRound(input bit sel);
    int h;
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    tick();
    if (sel) b_start = 1'b0; else a_start = 1'b0;
    waitRun(sel, h);
    checkOutput(sel ? "B.rsthold_len" : "A.rsthold_len", 71'(h), 71'd4);
  endtask

  initial begin
    int h, n;
    logic [29:0] mask;
    reset = 1'b0;
    applyStimulus(0, 1'b0, 64'd0, 30'd0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 64'd0, 30'd0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("A.reset_state", a_outs, RESET_OUTS);
    checkOutput("B.reset_state", b_outs, RESET_OUTS);
    reset = 1'b1;
    tick();

    // B: round times out after 50 RUN cycles
    b_tohost = randTohost(1'b0);
    startRound(1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (b_round_done) break;
      if (inRun(1)) n++;
      b_tohost = randTohost(1'b0);
      b_cov = 30'($urandom);
      tick();
    end
    checkOutput("B.timeout_done", 71'(b_round_done), 71'd1);
    checkOutput("B.timeout_run_cycles", 71'(n), 71'd50);
    checkOutput("B.timeout_status", 71'({b_clk_en, b_round_status, b_cycle_count}),
                {5'd0, 1'b0, 2'd2, 64'd50});

    // B: continue after reload, reset held four cycles with counters cleared
    tick();
    repeat ($urandom_range(0, 3)) tick();
    checkOutput("B.reload_req_held", 71'(b_reload_req), 71'd1);
    b_ack = 1'b1; b_cont = 1'b1;
    tick();
    b_ack = 1'b0; b_cont = 1'b0;
    checkOutput("B.rsthold_cleared", 71'({b_reload_req, b_round_status, b_cycle_count}), 71'd0);
    waitRun(1, h);
    checkOutput("B.rsthold_len_reload", 71'(h), 71'd4);

    // B: pass on the very cycle the limit is reached wins over timeout
    b_tohost = randTohost(1'b0);
    repeat (49) tick();
    b_tohost = randTohost(1'b1);
    tick();
    b_tohost = randTohost(1'b0);
    checkOutput("B.pass_at_limit", 71'({b_round_done, b_round_status, b_cycle_count}),
                {4'd0, 1'b1, 2'd1, 64'd50});
    tick();
    b_ack = 1'b1; b_cont = 1'b0;
    tick();
    b_ack = 1'b0;
    checkOutput("B.done_state", 71'({b_dut_reset, b_clk_en, b_reload_req}), 71'b100);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    checkOutput("B.done_ignores_start", 71'({b_dut_reset, b_clk_en}), 71'b10);

    // B: randomized rounds with spurious start/ack noise
    reset = 1'b0;
    tick();
    reset = 1'b1;
    startRound(1);
    for (int r = 0; r < 8; r++) begin
      int pass_at;
      int k;
      pass_at = int'($urandom_range(1, 60));
      k = 1;
      while (!b_round_done && k < 100) begin
        b_tohost = randTohost(k == pass_at);
        b_cov    = 30'($urandom);
        b_ack    = 1'($urandom_range(0, 1));
        b_cont   = 1'($urandom_range(0, 1));
        b_start  = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      checkOutput("B.random_round_end", 71'(b_round_done), 71'd1);
      b_tohost = randTohost(1'b0); b_ack = 1'b0; b_start = 1'b0;
      tick();
      repeat ($urandom_range(0, 4)) tick();
      b_ack = 1'b1; b_cont = (r < 7);
      tick();
      b_ack = 1'b0; b_cont = 1'b0;
      if (r < 7) waitRun(1, h);
    end

    // A: pass at RUN cycle 100, then reload without continue
    reset = 1'b0;
    tick();
    reset = 1'b1;
    startRound(0);
    repeat (99) begin
      a_cov = 30'($urandom);
      a_tohost = randTohost(1'b0);
      tick();
    end
    a_tohost = randTohost(1'b1);
    tick();
    a_tohost = randTohost(1'b0);
    checkOutput("A.pass_halt", 71'({a_round_done, a_clk_en, a_reload_req, a_round_status, a_cycle_count}),
                {2'd0, 1'b1, 1'b0, 1'b0, 2'd1, 64'd100});
    tick();
    checkOutput("A.reload_entry", 71'({a_reload_req, a_round_done, a_clk_en}), 71'b100);
    repeat ($urandom_range(0, 3)) tick();
    a_ack = 1'b1; a_cont = 1'b0;
    tick();
    a_ack = 1'b0;
    checkOutput("A.done_state", 71'({a_dut_reset, a_clk_en, a_reload_req}), 71'b100);

    // A: constant coverage stalls after the base threshold
    reset = 1'b0;
    tick();
    reset = 1'b1;
    a_cov = 30'd0;
    a_tohost = randTohost(1'b0);
    startRound(0);
    n = 1;
    while (!a_stall_irq && n < 3000) begin
      a_tohost = randTohost(1'b0);
      tick();
      n++;
    end
    checkOutput("A.stall_base_cycle", 71'(n), 71'd1001);

    // A: difficulty field 1 doubles the threshold
    a_tohost = randTohost(1'b1);
    tick();
    a_tohost = randTohost(1'b0);
    tick();
    a_ack = 1'b1; a_cont = 1'b1; a_cov = 30'h80000;
    tick();
    a_ack = 1'b0; a_cont = 1'b0;
    waitRun(0, h);
    n = 1;
    while (!a_stall_irq && n < 5000) begin
      tick();
      n++;
    end
    checkOutput("A.stall_scaled_cycle", 71'(n), 71'd2002);

    // A: coverage always moving, watchdog fires instead
    a_tohost = randTohost(1'b1);
    tick();
    a_tohost = randTohost(1'b0);
    tick();
    a_ack = 1'b1; a_cont = 1'b1;
    tick();
    a_ack = 1'b0; a_cont = 1'b0;
    mask = 30'($urandom_range(1, 32'h3FFF_FFFF));
    waitRun(0, h);
    n = 1;
    while (!a_stall_irq && n < 60000) begin
      a_cov = a_cov ^ mask;
      tick();
      n++;
    end
    checkOutput("A.watchdog_cycle", 71'(n), 71'd50001);

    // A: reset in the middle of a reload request
    a_tohost = randTohost(1'b1);
    tick();
    a_tohost = randTohost(1'b0);
    checkOutput("A.irq_low_in_halt", 71'(a_stall_irq), 71'd0);
    tick();
    tick();
    checkOutput("A.reload_req_before_reset", 71'(a_reload_req), 71'd1);
    reset = 1'b0;
    tick();
    checkOutput("A.reset_mid_reload", a_outs, RESET_OUTS);
    reset = 1'b1;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fuzz_round_sequencer.md
FUZZ_ROUND_SEQUENCER -- requirements
Module: fuzz_round_sequencer

Interface
REQ-001 SHALL have parameter MAX_WAIT_CYCLE, default 1000, base stall threshold in cycles.
REQ-002 SHALL have parameter WATCHDOG_LIMIT, default 50000, cycles without tohost[0] before stall_irq.
REQ-003 SHALL have parameter MAX_CYCLES, default 2000000000, round timeout in cycles.
REQ-004 SHALL have parameter RESET_HOLD, default 4, DUT reset pulse length in cycles (>=1).
REQ-005 SHALL have port clock  input  1  block clock.
REQ-006 SHALL have port reset  input  1  synchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle pulse; begins fuzzing from IDLE.
REQ-008 SHALL have port tohost  input  64  co-simulation tohost word; bit0 = round pass.
REQ-009 SHALL have port cov  input  30  coverage summary from the DUT.
REQ-010 SHALL have port reload_ack  input  1  loader has reloaded memory and collected coverage.
REQ-011 SHALL have port reload_continue  input  1  sampled with reload_ack; 1 = run another round.
REQ-012 SHALL have port dut_reset  output  1  active-high reset to base and variant harnesses.
REQ-013 SHALL have port clk_en  output  1  DUT clock-gate enable.
REQ-014 SHALL have port stall_irq  output  1  software interrupt (msip) to the DUT.
REQ-015 SHALL have port reload_req  output  1  request to loader; held until reload_ack.
REQ-016 SHALL have port round_done  output  1  one-cycle pulse at round end.
REQ-017 SHALL have port round_status  output  2  0 NONE, 1 PASS, 2 TIMEOUT; held until next round starts.
REQ-018 SHALL have port cycle_count  output  64  cycles elapsed in current round.

Function
REQ-019 SHALL implement states IDLE, RSTHOLD, RUN, HALT, RELOAD, DONE.
REQ-020 IDLE: dut_reset=1, clk_en=1; start -> RSTHOLD; start in any other state ignored.
REQ-021 RSTHOLD: dut_reset=1, clk_en=1 for exactly RESET_HOLD cycles, then RUN; cycle_count, stall and watchdog counters, pre_cov cleared; round_status -> NONE on entry.
REQ-022 RUN: dut_reset=0, clk_en=1; cycle_count increments by 1 per cycle, saturating at 2^64-1.
REQ-023 RUN: tohost[0]=1 -> round_status=PASS, next state HALT.
REQ-024 RUN: cycle_count >= MAX_CYCLES and tohost[0]=0 -> round_status=TIMEOUT, HALT; PASS wins on same-cycle coincidence.
REQ-025 HALT: clk_en=0, dut_reset=0, round_done=1 for this single cycle, then RELOAD.
REQ-026 RELOAD: clk_en=0, reload_req=1 from entry until the cycle reload_ack=1 (inclusive), deasserted the following cycle.
REQ-027 RELOAD on reload_ack: reload_continue=1 -> RSTHOLD; 0 -> DONE; reload_ack outside RELOAD ignored.
REQ-028 DONE: clk_en=0, dut_reset=1; terminal until reset.
REQ-029 Stall counter, RUN only: cov != pre_cov -> pre_cov<=cov, counter<=0; else counter+1; tohost[0]=1 clears counter and watchdog; counters saturate.
REQ-030 Watchdog, RUN only: +1 per cycle when tohost[0]=0.
REQ-031 Stall threshold = MAX_WAIT_CYCLE * (cov[29:19] + 1), computed at 32 bits, no overflow.
REQ-032 stall_irq = RUN and (stall counter >= threshold or watchdog >= WATCHDOG_LIMIT), from registered counters; 0 in all other states.

Reset
REQ-033 reset=0 at a clock edge SHALL force IDLE, dut_reset=1, clk_en=1, stall_irq=0, reload_req=0, round_done=0, round_status=NONE, cycle_count=0, all counters and pre_cov =0, from any state including mid-RELOAD.

Structure
REQ-034 Package fuzz_seq_pkg SHALL hold the state enum, round_status enum and parameter defaults.
REQ-035 Stall/watchdog counters and threshold SHALL be sub-module fuzz_stall_monitor; FSM and cycle counter in the top.

Verification
REQ-036 start, tohost=1 at RUN cycle 100 -> PASS, round_done one cycle, clk_en=0, reload_req=1; ack+continue=0 -> DONE, dut_reset=1.
REQ-037 cov=0 constant, tohost=0 -> stall_irq rises when stall counter reaches 1000; cov=0x80000 constant -> rises at 2000.
REQ-038 cov toggling each cycle, tohost=0 -> stall_irq rises at watchdog=50000.
REQ-039 MAX_CYCLES=50, tohost=0 -> TIMEOUT, HALT after 50 RUN cycles; tohost=1 same cycle as limit -> PASS.
REQ-040 reload_continue=1 on ack -> dut_reset high exactly 4 cycles, cycle_count=0, status NONE, RUN resumes.
REQ-041 reset=0 while reload_req=1 -> next cycle IDLE, reload_req=0, all outputs at reset values.
